// File: rtl/csl_task_scheduler.sv
// CSL task scheduler: queues PU/FU/WU requests and issues them one at a time
// to the bot, holding each until task_complete or the watchdog aborts it.
module csl_task_scheduler #(
  parameter int          DEPTH    = 4,
  parameter int unsigned TIMEOUT  = 50_000_000,
  parameter logic [4:0]  PU_START = 5'd10,
  parameter logic [4:0]  PU_END   = 5'd30,
  parameter logic [4:0]  PU_PREV  = 5'd28,
  parameter logic [4:0]  FU_START = 5'd24,
  parameter logic [4:0]  FU_END   = 5'd19,
  parameter logic [4:0]  FU_PREV  = 5'd18,
  parameter logic [4:0]  WU_START = 5'd18,
  parameter logic [4:0]  WU_END   = 5'd11,
  parameter logic [4:0]  WU_PREV  = 5'd12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [1:0]               req_unit,
  output logic                     req_ready,
  input  logic                     task_complete,
  output logic                     task_start,
  output logic                     task_busy,
  output logic [1:0]               unit_type,
  output logic [4:0]               csl_start,
  output logic [4:0]               csl_end,
  output logic [4:0]               csl_prev_node_of_end_point,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     overflow_err,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   wdog;

  logic       req_ok;
  logic       full;
  logic       pop;
  logic       push;
  logic       wd_hit;
  logic [1:0] head;
  logic [4:0] n_start;
  logic [4:0] n_end;
  logic [4:0] n_prev;

  assign req_ok      = req_valid && (req_unit != 2'd0);
  assign full        = (count == FULL);
  assign pop         = (state == IDLE) && (count != '0);
  assign push        = req_ok && (!full || pop);
  assign req_ready   = !full;
  assign queue_count = count;
  assign head        = mem[rd_ptr];
  assign wd_hit      = (TIMEOUT != 0) && (wdog == WD_LAST);

  always_comb begin
    n_start = 5'd0;
    n_end   = 5'd0;
    n_prev  = 5'd0;
    case (head)
      2'd1: begin
        n_start = PU_START;
        n_end   = PU_END;
        n_prev  = PU_PREV;
      end
      2'd2: begin
        n_start = FU_START;
        n_end   = FU_END;
        n_prev  = FU_PREV;
      end
      2'd3: begin
        n_start = WU_START;
        n_end   = WU_END;
        n_prev  = WU_PREV;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_unit;
  end

  // On a full queue a same-edge pop frees the slot being written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                      <= IDLE;
      wdog                       <= '0;
      task_start                 <= 1'b0;
      task_busy                  <= 1'b0;
      unit_type                  <= 2'd0;
      csl_start                  <= 5'd0;
      csl_end                    <= 5'd0;
      csl_prev_node_of_end_point <= 5'd0;
      overflow_err               <= 1'b0;
      timeout_err                <= 1'b0;
    end else begin
      task_start   <= 1'b0;
      timeout_err  <= 1'b0;
      overflow_err <= req_ok && full && !pop;
      case (state)
        IDLE: begin
          if (pop) begin
            state                      <= RUN;
            task_start                 <= 1'b1;
            task_busy                  <= 1'b1;
            unit_type                  <= head;
            csl_start                  <= n_start;
            csl_end                    <= n_end;
            csl_prev_node_of_end_point <= n_prev;
            wdog                       <= '0;
          end
        end
        RUN: begin
          if (task_complete || wd_hit) begin
            state                      <= DONE;
            timeout_err                <= !task_complete;
            task_busy                  <= 1'b0;
            unit_type                  <= 2'd0;
            csl_start                  <= 5'd0;
            csl_end                    <= 5'd0;
            csl_prev_node_of_end_point <= 5'd0;
            wdog                       <= '0;
          end else if (wdog != '1) begin
            wdog <= wdog + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csl_task_scheduler.sv
// Scoreboard bench for csl_task_scheduler: expected issues are queued at push
// time and checked by a monitor whenever task_start is seen.
module tb_csl_task_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_unit;
  logic       req_ready;
  logic       task_complete;
  logic       task_start;
  logic       task_busy;
  logic [1:0] unit_type;
  logic [4:0] csl_start;
  logic [4:0] csl_end;
  logic [4:0] csl_prev;
  logic [2:0] queue_count;
  logic       overflow_err;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;

  csl_task_scheduler #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .req_valid                  (req_valid),
    .req_unit                   (req_unit),
    .req_ready                  (req_ready),
    .task_complete              (task_complete),
    .task_start                 (task_start),
    .task_busy                  (task_busy),
    .unit_type                  (unit_type),
    .csl_start                  (csl_start),
    .csl_end                    (csl_end),
    .csl_prev_node_of_end_point (csl_prev),
    .queue_count                (queue_count),
    .overflow_err               (overflow_err),
    .timeout_err                (timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp_v);
    end
  endtask

  function automatic logic [16:0] exp_of(input logic [1:0] u);
    case (u)
      2'd1:    return {2'd1, 5'd10, 5'd30, 5'd28};
      2'd2:    return {2'd2, 5'd24, 5'd19, 5'd18};
      2'd3:    return {2'd3, 5'd18, 5'd11, 5'd12};
      default: return 17'd0;
    endcase
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({task_start, task_busy, unit_type, csl_start, csl_end,
                csl_prev, queue_count, overflow_err, timeout_err});
  endfunction

  task automatic push(input logic [1:0] u, input bit accept);
    req_valid = 1'b1;
    req_unit  = u;
    if (accept) exp_q.push_back(exp_of(u));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_unit  = 2'd0;
  endtask

  task automatic complete();
    task_complete = 1'b1;
    @(posedge clk);
    #1;
    task_complete = 1'b0;
  endtask

  task automatic wait_start(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (task_start) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s got no task_start exp task_start", name);
    end
  endtask

  // Monitor: every issued task must match the head of the scoreboard.
  always @(negedge clk) begin
    if (task_start) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected got unit %0d exp none", unit_type);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue", 32'({unit_type, csl_start, csl_end, csl_prev}),
              32'(mon_e));
        check("issue_busy", 32'(task_busy), 32'd1);
      end
    end
  end

  initial begin
    bit seen;
    rst = 1'b1;
    req_valid = 1'b0;
    req_unit = 2'd0;
    task_complete = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", all_outs(), 32'd0);
    check("reset_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // single PU issue and latency
    push(2'd1, 1'b1);
    @(negedge clk);
    check("lat_k", 32'(task_start), 32'd0);
    check("lat_k_qcount", 32'(queue_count), 32'd1);
    @(negedge clk);
    check("lat_k1", 32'(task_start), 32'd1);

    // FU, WU queued behind PU
    push(2'd2, 1'b1);
    push(2'd3, 1'b1);
    @(negedge clk);
    check("qcount_2", 32'(queue_count), 32'd2);
    complete();
    @(negedge clk);
    check("done_outs", 32'({task_busy, unit_type, csl_start, csl_end, csl_prev}),
          32'd0);
    wait_start("fu_start");
    complete();
    wait_start("wu_start");
    complete();

    // unit 0 ignored, task_complete in IDLE ignored
    repeat (2) @(negedge clk);
    req_valid = 1'b1;
    req_unit = 2'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    task_complete = 1'b1;
    @(posedge clk);
    #1 task_complete = 1'b0;
    @(negedge clk);
    check("unit0_qcount", 32'(queue_count), 32'd0);
    check("unit0_ovf", 32'(overflow_err), 32'd0);
    repeat (3) @(negedge clk);
    check("idle_quiet", 32'({task_start, task_busy}), 32'd0);

    // overflow while a task is stalled
    push(2'd1, 1'b1);
    wait_start("ovf_head");
    push(2'd2, 1'b1);
    push(2'd3, 1'b1);
    push(2'd1, 1'b1);
    push(2'd2, 1'b1);
    check("full_qcount", 32'(queue_count), 32'd4);
    check("full_ready", 32'(req_ready), 32'd0);
    push(2'd3, 1'b0);
    @(negedge clk);
    check("ovf_pulse", 32'(overflow_err), 32'd1);
    check("ovf_qcount", 32'(queue_count), 32'd4);
    @(negedge clk);
    check("ovf_clear", 32'(overflow_err), 32'd0);
    complete();
    @(posedge clk);
    #1;
    push(2'd3, 1'b1);
    check("pushpop_start", 32'(task_start), 32'd1);
    check("pushpop_qcount", 32'(queue_count), 32'd4);
    check("pushpop_ovf", 32'(overflow_err), 32'd0);
    complete();
    repeat (3) begin
      wait_start("drain");
      complete();
    end

    // watchdog abort, then next queued task issues
    wait_start("to_start");
    t0 = cyc;
    push(2'd1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (timeout_err) begin
        seen = 1'b1;
        break;
      end
    end
    check("timeout_seen", 32'(seen), 32'd1);
    check("timeout_dist", 32'(cyc - t0), 32'd8);
    check("timeout_busy", 32'(task_busy), 32'd0);
    @(negedge clk);
    check("timeout_clear", 32'(timeout_err), 32'd0);
    wait_start("after_timeout");

    // reset mid-RUN with 3 queued
    push(2'd1, 1'b1);
    push(2'd2, 1'b1);
    push(2'd3, 1'b1);
    check("pre_rst_qcount", 32'(queue_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("rst_outs", all_outs(), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_idle", 32'({task_start, task_busy, timeout_err}), 32'd0);
    end
    push(2'd2, 1'b1);
    wait_start("post_rst_start");
    complete();
    repeat (3) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
